// File: rtl/ddr_wr_burst_tx.sv
// rtl/ddr_wr_burst_tx.sv - DDR write burst transmitter: beat pairs to DQ/DM/DQS with preamble/postamble framing
module ddr_wr_burst_tx #(
    parameter int WIDTH       = 8,
    parameter int BURST_BEATS = 8,
    parameter bit SEAMLESS    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_d0,
    input  logic [WIDTH-1:0] s_d1,
    input  logic [1:0]       s_dm,
    output logic [WIDTH-1:0] dq_o,
    output logic             dq_oe,
    output logic             dm_o,
    output logic             dqs_o,
    output logic             dqs_oe,
    output logic             busy,
    output logic             underrun
);
    localparam int PAIRS = BURST_BEATS / 2;
    localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [CW-1:0] LAST = CW'(PAIRS - 1);

    typedef enum logic [1:0] {IDLE, PRE, BURST, POST} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            accept, under;

    logic [WIDTH-1:0] p_dq, f_dq, n_dq;
    logic             p_dm, f_dm, n_dm;
    logic             tog_q, underrun_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid) state_d = PRE;
            end
            PRE: begin
                s_ready = 1'b1;
                state_d = BURST;
                cnt_d   = '0;
            end
            BURST: begin
                if (cnt_q != LAST) begin
                    s_ready = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    s_ready = SEAMLESS;
                    if (SEAMLESS && s_valid) cnt_d = '0;
                    else                     state_d = POST;
                end
            end
            POST: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        accept = s_ready & s_valid;
        // A missing pair on the final seamless slot just ends the burst; it is not a hole.
        under  = s_ready & ~s_valid & ~(state_q == BURST && cnt_q == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            p_dq       <= '0;
            p_dm       <= 1'b0;
            f_dq       <= '0;
            f_dm       <= 1'b0;
            tog_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tog_q      <= (state_d == BURST);
            underrun_q <= under;
            if (accept) begin
                p_dq <= s_d0;
                p_dm <= s_dm[0];
                f_dq <= s_d1;
                f_dm <= s_dm[1];
            end else if (under) begin
                // Hole in the burst: repeat the last driven beat, masked in both phases.
                p_dq <= f_dq;
                p_dm <= 1'b1;
                f_dm <= 1'b1;
            end else begin
                p_dq <= '0;
                p_dm <= 1'b0;
                f_dq <= '0;
                f_dm <= 1'b0;
            end
        end
    end

    always_ff @(negedge clk) begin
        n_dq <= f_dq;
        n_dm <= f_dm;
    end

    assign dq_o     = clk ? p_dq : n_dq;
    assign dm_o     = clk ? p_dm : n_dm;
    assign dqs_o    = clk & tog_q;
    assign dq_oe    = (state_q == BURST);
    assign dqs_oe   = (state_q != IDLE);
    assign busy     = (state_q != IDLE);
    assign underrun = underrun_q;
endmodule

// File: tb/tb_ddr_wr_burst_tx.sv
// tb/tb_ddr_wr_burst_tx.sv - self-checking bench for ddr_wr_burst_tx (SEAMLESS=0 and SEAMLESS=1 instances)
module tb_ddr_wr_burst_tx;
    localparam int PAIRS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sv   [2];
    logic [7:0] sd0  [2];
    logic [7:0] sd1  [2];
    logic [1:0] sdm  [2];
    logic       rdy  [2];
    logic [7:0] dqw  [2];
    logic       dqoe [2];
    logic       dmw  [2];
    logic       dqsw [2];
    logic       dqsoe[2];
    logic       bsy  [2];
    logic       urw  [2];

    ddr_wr_burst_tx #(.WIDTH(8), .BURST_BEATS(8), .SEAMLESS(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .s_valid(sv[0]), .s_ready(rdy[0]),
        .s_d0(sd0[0]), .s_d1(sd1[0]), .s_dm(sdm[0]),
        .dq_o(dqw[0]), .dq_oe(dqoe[0]), .dm_o(dmw[0]), .dqs_o(dqsw[0]),
        .dqs_oe(dqsoe[0]), .busy(bsy[0]), .underrun(urw[0])
    );

    ddr_wr_burst_tx #(.WIDTH(8), .BURST_BEATS(8), .SEAMLESS(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .s_valid(sv[1]), .s_ready(rdy[1]),
        .s_d0(sd0[1]), .s_d1(sd1[1]), .s_dm(sdm[1]),
        .dq_o(dqw[1]), .dq_oe(dqoe[1]), .dm_o(dmw[1]), .dqs_o(dqsw[1]),
        .dqs_oe(dqsoe[1]), .busy(bsy[1]), .underrun(urw[1])
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(string name, int d, logic [14:0] act, logic [14:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
    endtask

    // Reference model: position within a frame (0 = preamble, 1..PAIRS = data slots,
    // PAIRS+1 = postamble); beats are {mask, data}.
    bit         m_act [2];
    int         m_pos [2];
    logic [8:0] m_p   [2];
    logic [8:0] m_f   [2];
    bit         m_ur  [2];
    bit         m_acc [2];

    function automatic bit m_ready(int d);
        return m_act[d] && (m_pos[d] == 0 || (m_pos[d] >= 1 && m_pos[d] < PAIRS) ||
                            (m_pos[d] == PAIRS && d == 1));
    endfunction

    function automatic bit m_dataslot(int d);
        return m_act[d] && m_pos[d] >= 1 && m_pos[d] <= PAIRS;
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit r, acc, und;
            r   = m_ready(d);
            acc = r && sv[d] && !rst;
            und = r && !sv[d] && m_pos[d] != PAIRS;
            m_acc[d] = acc;
            if (rst) begin
                m_act[d] = 0; m_pos[d] = 0; m_p[d] = '0; m_f[d] = '0; m_ur[d] = 0;
            end else begin
                if (acc) begin
                    m_p[d] = {sdm[d][0], sd0[d]};
                    m_f[d] = {sdm[d][1], sd1[d]};
                end else if (und) begin
                    m_p[d] = {1'b1, m_f[d][7:0]};
                    m_f[d] = m_p[d];
                end else begin
                    m_p[d] = '0;
                    m_f[d] = '0;
                end
                m_ur[d] = und;
                if (!m_act[d]) begin
                    if (sv[d]) begin m_act[d] = 1; m_pos[d] = 0; end
                end else if (m_pos[d] < PAIRS) m_pos[d]++;
                else if (m_pos[d] == PAIRS) m_pos[d] = (d == 1 && acc) ? 1 : PAIRS + 1;
                else m_act[d] = 0;
            end
        end
    endtask

    logic [14:0] hi_obs [2];
    logic [11:0] lo_obs [2];

    task automatic cyc();
        @(posedge clk);
        model_step();
        #2;
        for (int d = 0; d < 2; d++) begin
            hi_obs[d] = {rdy[d], bsy[d], urw[d], dqoe[d], dqsoe[d], dqsw[d], dmw[d], dqw[d]};
            check("model_hi", d, hi_obs[d],
                  {m_ready(d), m_act[d], m_ur[d], m_dataslot(d), m_act[d], m_dataslot(d), m_p[d]});
        end
        @(negedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            lo_obs[d] = {dqoe[d], dqsoe[d], dqsw[d], dmw[d], dqw[d]};
            check("model_lo", d, {3'b0, lo_obs[d]},
                  {3'b0, m_dataslot(d), m_act[d], 1'b0, m_f[d]});
        end
    endtask

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] m;
    } pair_t;

    pair_t q0[$];
    pair_t q1[$];

    task automatic present(int d, bit allow);
        pair_t p;
        int    n;
        n = (d == 0) ? q0.size() : q1.size();
        if (!sv[d] && n > 0 && allow) begin
            p = (d == 0) ? q0[0] : q1[0];
            sv[d] = 1'b1; sd0[d] = p.a; sd1[d] = p.b; sdm[d] = p.m;
        end
    endtask

    task automatic retire();
        if (m_acc[0]) begin void'(q0.pop_front()); sv[0] = 1'b0; end
        if (m_acc[1]) begin void'(q1.pop_front()); sv[1] = 1'b0; end
    endtask

    typedef struct {
        bit          rst;
        bit          v;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [1:0]  dm;
        logic [14:0] hi;
        logic [11:0] lo;
    } vec_t;

    function automatic vec_t mk(bit r, bit v, logic [7:0] d0, logic [7:0] d1, logic [1:0] dm,
                                bit ry, bit by, bit ur, bit doe, bit soe,
                                logic [7:0] dqh, logic [7:0] dql, bit dmh, bit dml);
        vec_t t;
        t.rst = r; t.v = v; t.d0 = d0; t.d1 = d1; t.dm = dm;
        t.hi  = {ry, by, ur, doe, soe, doe, dmh, dqh};
        t.lo  = {doe, soe, 1'b0, dml, dql};
        return t;
    endfunction

    vec_t tbl[$];
    int   oe_cnt [2];
    int   soe_cnt[2];
    int   dqs_cnt[2];
    int   rises  [2];
    bit   prev_oe[2];
    int   first_fall, second_rise;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            sv[d] = 1'b0; sd0[d] = '0; sd1[d] = '0; sdm[d] = '0;
        end

        // reset and idle
        for (int i = 0; i < 3; i++)  tbl.push_back(mk(1,0,8'h00,8'h00,2'b00, 0,0,0,0,0, 8'h00,8'h00,0,0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(0,0,8'h00,8'h00,2'b00, 0,0,0,0,0, 8'h00,8'h00,0,0));
        // single burst 01..08
        tbl.push_back(mk(0,1,8'h01,8'h02,2'b00, 1,1,0,0,1, 8'h00,8'h00,0,0));
        tbl.push_back(mk(0,1,8'h01,8'h02,2'b00, 1,1,0,1,1, 8'h01,8'h02,0,0));
        tbl.push_back(mk(0,1,8'h03,8'h04,2'b00, 1,1,0,1,1, 8'h03,8'h04,0,0));
        tbl.push_back(mk(0,1,8'h05,8'h06,2'b00, 1,1,0,1,1, 8'h05,8'h06,0,0));
        tbl.push_back(mk(0,1,8'h07,8'h08,2'b00, 0,1,0,1,1, 8'h07,8'h08,0,0));
        tbl.push_back(mk(0,0,8'h00,8'h00,2'b00, 0,1,0,0,1, 8'h00,8'h00,0,0));
        tbl.push_back(mk(0,0,8'h00,8'h00,2'b00, 0,0,0,0,0, 8'h00,8'h00,0,0));
        // second pair missing
        tbl.push_back(mk(0,1,8'h01,8'h02,2'b00, 1,1,0,0,1, 8'h00,8'h00,0,0));
        tbl.push_back(mk(0,1,8'h01,8'h02,2'b00, 1,1,0,1,1, 8'h01,8'h02,0,0));
        tbl.push_back(mk(0,0,8'h00,8'h00,2'b00, 1,1,1,1,1, 8'h02,8'h02,1,1));
        tbl.push_back(mk(0,1,8'h05,8'h06,2'b00, 1,1,0,1,1, 8'h05,8'h06,0,0));
        tbl.push_back(mk(0,1,8'h07,8'h08,2'b00, 0,1,0,1,1, 8'h07,8'h08,0,0));
        tbl.push_back(mk(0,0,8'h00,8'h00,2'b00, 0,1,0,0,1, 8'h00,8'h00,0,0));
        tbl.push_back(mk(0,0,8'h00,8'h00,2'b00, 0,0,0,0,0, 8'h00,8'h00,0,0));
        // mask on the falling beat, then the rest of the burst missing
        tbl.push_back(mk(0,1,8'hAA,8'h55,2'b10, 1,1,0,0,1, 8'h00,8'h00,0,0));
        tbl.push_back(mk(0,1,8'hAA,8'h55,2'b10, 1,1,0,1,1, 8'hAA,8'h55,0,1));
        tbl.push_back(mk(0,0,8'h00,8'h00,2'b00, 1,1,1,1,1, 8'h55,8'h55,1,1));
        tbl.push_back(mk(0,0,8'h00,8'h00,2'b00, 1,1,1,1,1, 8'h55,8'h55,1,1));
        tbl.push_back(mk(0,0,8'h00,8'h00,2'b00, 0,1,1,1,1, 8'h55,8'h55,1,1));
        tbl.push_back(mk(0,0,8'h00,8'h00,2'b00, 0,1,0,0,1, 8'h00,8'h00,0,0));
        tbl.push_back(mk(0,0,8'h00,8'h00,2'b00, 0,0,0,0,0, 8'h00,8'h00,0,0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            for (int d = 0; d < 2; d++) begin
                sv[d] = tbl[i].v; sd0[d] = tbl[i].d0; sd1[d] = tbl[i].d1; sdm[d] = tbl[i].dm;
            end
            cyc();
            check($sformatf("tbl%0d_hi", i), 0, hi_obs[0], tbl[i].hi);
            check($sformatf("tbl%0d_lo", i), 0, {3'b0, lo_obs[0]}, {3'b0, tbl[i].lo});
        end
        for (int d = 0; d < 2; d++) sv[d] = 1'b0;

        // eight pairs offered back to back to both instances
        for (int i = 0; i < 8; i++) begin
            q0.push_back(pair_t'({8'(2*i+1), 8'(2*i+2), 2'b00}));
            q1.push_back(pair_t'({8'(2*i+1), 8'(2*i+2), 2'b00}));
        end
        for (int d = 0; d < 2; d++) begin
            oe_cnt[d] = 0; soe_cnt[d] = 0; dqs_cnt[d] = 0; rises[d] = 0; prev_oe[d] = 0;
        end
        first_fall = -1; second_rise = -1;
        for (int k = 0; k < 20; k++) begin
            present(0, 1'b1); present(1, 1'b1);
            cyc();
            retire();
            for (int d = 0; d < 2; d++) begin
                if (hi_obs[d][11]) oe_cnt[d]++;
                if (hi_obs[d][10]) soe_cnt[d]++;
                if (hi_obs[d][9])  dqs_cnt[d]++;
                if (hi_obs[d][11] && !prev_oe[d]) begin
                    rises[d]++;
                    if (d == 0 && rises[d] == 2) second_rise = k;
                end
                if (d == 0 && !hi_obs[d][11] && prev_oe[d] && first_fall < 0) first_fall = k;
                prev_oe[d] = hi_obs[d][11];
            end
        end
        check("seam_dqs_oe_cycles", 1, 15'(soe_cnt[1]), 15'd10);
        check("seam_dq_oe_cycles",  1, 15'(oe_cnt[1]),  15'd8);
        check("seam_dq_oe_rises",   1, 15'(rises[1]),   15'd1);
        check("seam_dqs_pulses",    1, 15'(dqs_cnt[1]), 15'd8);
        check("gap_dqs_oe_cycles",  0, 15'(soe_cnt[0]), 15'd12);
        check("gap_dq_oe_cycles",   0, 15'(oe_cnt[0]),  15'd8);
        check("gap_dq_oe_rises",    0, 15'(rises[0]),   15'd2);
        check("gap_dq_oe_low_len",  0, 15'(second_rise - first_fall), 15'd3);

        // reset while in the second data slot, then a clean restart
        for (int i = 0; i < 4; i++) begin
            q0.push_back(pair_t'({8'(8'h40 + 2*i), 8'(8'h41 + 2*i), 2'b00}));
            q1.push_back(pair_t'({8'(8'h40 + 2*i), 8'(8'h41 + 2*i), 2'b00}));
        end
        for (int k = 0; k < 3; k++) begin
            present(0, 1'b1); present(1, 1'b1);
            cyc();
            retire();
        end
        rst = 1'b1;
        present(0, 1'b1); present(1, 1'b1);
        cyc();
        retire();
        for (int d = 0; d < 2; d++)
            check("midrst_rdy_busy_oe", d, {11'b0, hi_obs[d][14], hi_obs[d][13], hi_obs[d][11], hi_obs[d][10]}, 15'b0000);
        rst = 1'b0;
        cyc();
        retire();
        for (int d = 0; d < 2; d++)
            check("restart_pre", d, {11'b0, hi_obs[d][14], hi_obs[d][13], hi_obs[d][11], hi_obs[d][10]}, 15'b1101);
        for (int k = 0; k < 10; k++) begin
            present(0, 1'b1); present(1, 1'b1);
            cyc();
            retire();
        end

        // randomized traffic with gaps and occasional resets
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (q0.size() < 3 && $urandom_range(0, 3) != 0)
                q0.push_back(pair_t'({8'($urandom), 8'($urandom), 2'($urandom)}));
            if (q1.size() < 3 && $urandom_range(0, 3) != 0)
                q1.push_back(pair_t'({8'($urandom), 8'($urandom), 2'($urandom)}));
            present(0, $urandom_range(0, 4) != 0);
            present(1, $urandom_range(0, 4) != 0);
            cyc();
            retire();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ddr_wr_burst_tx.md
Name: ddr_wr_burst_tx

Overview:
- Write-direction counterpart of the DDR capture path: an 8-bit DQ burst transmitter.
- Accepts rise/fall beat pairs (d0 and d1, one pair per clk) over a valid/ready handshake.
- Drives DQ, DM and DQS on both clk edges, with DQS preamble, postamble and output-enable framing.
- Sits between the write-data FIFO and the pad/delay cells; the 90-degree DQS shift is applied downstream, so DQS leaves this block edge-aligned.

Parameters:
WIDTH, 8, DQ lane width
BURST_BEATS, 8, beats per burst; even, >=2; PAIRS = BURST_BEATS/2
SEAMLESS, 1, 1 = back-to-back bursts without postamble/preamble gap

Ports:
clk  in  1  single clock; both edges used in output stage
rst  in  1  synchronous reset, active-high
s_valid  in  1  beat pair valid
s_ready  out  1  beat pair accepted when s_valid&s_ready at posedge
s_d0  in  WIDTH  rising-edge beat
s_d1  in  WIDTH  falling-edge beat
s_dm  in  2  mask: [0] for d0, [1] for d1
dq_o  out  WIDTH  DDR data to pad
dq_oe  out  1  DQ/DM output enable
dm_o  out  1  DDR data mask
dqs_o  out  1  DDR strobe
dqs_oe  out  1  strobe output enable
busy  out  1  state != IDLE
underrun  out  1  one-cycle pulse, pair missing inside a burst

Behaviour:
- States: IDLE, PRE, BURST, POST; 2-bit counter cnt (0..PAIRS-1) valid in BURST.
- IDLE: s_ready=0. If s_valid, go to PRE; the pair is not consumed in IDLE.
- PRE: dqs_oe=1, dqs_o=0, dq_oe=0, s_ready=1. Always go to BURST with cnt=0.
- BURST: dq_oe=dqs_oe=1; dqs_o = clk (high phase 1, low phase 0), i.e. one DQS pulse per cycle.
  - s_ready=1 when cnt<PAIRS-1.
  - When cnt==PAIRS-1, s_ready=SEAMLESS.
- Data latency: a pair accepted at posedge N appears on the bus in cycle N+1.
  - dq_o = d0 in the clk-high phase and d1 in the clk-low phase.
  - dm_o follows s_dm[0] then s_dm[1].
- Output stage:
  - Posedge registers p_q (d0, dm0), f_q (d1, dm1) and tog_q.
  - Negedge register n_q loads f_q.
  - dq_o/dm_o = clk ? p_q : n_q; dqs_o = clk & tog_q.
- Underrun: s_ready=1 and s_valid=0 in PRE, or in BURST with cnt<PAIRS-1.
  - Next bus cycle: dq_o holds the previous value, dm_o=1 in both phases, dqs still toggles.
  - cnt still advances, so the burst length stays fixed.
  - underrun pulses high for that cycle.
- BURST, cnt<PAIRS-1: cnt++.
- BURST, cnt==PAIRS-1:
  - If SEAMLESS and a pair is accepted, stay in BURST with cnt=0.
  - Otherwise go to POST.
- POST: dqs_oe=1, dqs_o=0, dq_oe=0, dm_o=0, s_ready=0. Go to IDLE regardless of s_valid; a new burst takes PRE again.
- IDLE outputs: dq_o=0, dm_o=0, dqs_o=0, all oe=0, underrun=0, busy=0.
- Reset (rst sampled high at posedge):
  - State to IDLE, cnt=0, all posedge registers 0; n_q clears at the following negedge.
  - Mid-burst reset: oe outputs drop in the next cycle; the partial burst is abandoned and no postamble is issued.
- Simultaneous reset and s_valid: reset wins and the pair is not accepted.
- Source contract: s_valid/s_d0/s_d1/s_dm held until accepted. The block never consumes a pair when s_ready=0.

Test Plan:
1. Idle/reset: rst 3 cycles, s_valid=0 -> all outputs 0, busy=0, s_ready=0; after release, outputs stay 0 for 10 cycles.
2. Single burst (BURST_BEATS=8, SEAMLESS=0):
   - Stimulus: pairs (01,02),(03,04),(05,06),(07,08) held valid.
   - s_ready high 4 cycles starting the cycle after s_valid rises.
   - dqs_oe high 6 cycles (PRE, 4 BURST, POST), dq_oe high 4 cycles.
   - dq_o half-cycle sequence 01..08; 4 DQS pulses; dm_o=0.
3. Underrun: s_valid low for the 2nd pair -> 2nd bus cycle dq_o holds 02 with dm_o=1 both phases, underrun pulses once, burst still 4 cycles, then 4th pair delivered.
4. Seamless:
   - SEAMLESS=1, 8 pairs continuous -> 8 BURST cycles, one PRE and one POST, dqs_oe 10 cycles, no DQS gap.
   - SEAMLESS=0, same stimulus -> POST, IDLE, PRE between bursts (3-cycle gap in dq_oe).
5. Mask: pair (AA,55) with s_dm=2'b10 -> dm_o 0 in high phase, 1 in low phase, dq_o AA then 55.
6. Reset mid-burst at BURST cnt=1 -> next cycle dq_oe=dqs_oe=0, busy=0, s_ready=0; a new s_valid afterwards starts cleanly with PRE.
